sr_dmem: RTL and testbench

- Data-memory responder for the single-cycle sr_cpu load/store port.
- Answers the CPU's dmAddr/dmDataW/dmWe/op_byte/op_half/op_word/dmSign strobes with dmDataR in the same cycle. Writes commit at the clock edge.
- Provides word-organised RAM with byte/half/word lanes, load sign/zero extension and misalignment detection.
- Provides a small MMIO page: GPIO output register, free-running cycle counter, misaligned-access error counter and error address.

---
 rtl/sr_dmem_pkg.sv | 16 +
 rtl/sr_dmem_align.sv | 30 +++
 rtl/sr_dmem.sv | 83 ++++++++
 tb/tb_sr_dmem.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sr_dmem_pkg.sv
// sr_dmem_pkg: access-width codes, MMIO offsets and the width priority encoder.
package sr_dmem_pkg;
  typedef enum logic [1:0] {
    W_NONE = 2'd0,
    W_BYTE = 2'd1,
    W_HALF = 2'd2,
    W_WORD = 2'd3
  } width_e;
  localparam logic [11:0] DM_GPIO    = 12'h000;
  localparam logic [11:0] DM_CYCLE   = 12'h004;
  localparam logic [11:0] DM_ERRCNT  = 12'h008;
  localparam logic [11:0] DM_ERRADDR = 12'h00C;
  function automatic width_e width_sel(input logic b, input logic h, input logic w);
    return w ? W_WORD : h ? W_HALF : b ? W_BYTE : W_NONE;
  endfunction
endpackage

// File: rtl/sr_dmem_align.sv
// sr_dmem_align: byte enables, store lane replication, load extension and misalignment.
module sr_dmem_align
  import sr_dmem_pkg::*;
(
  input  width_e      width,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic        sign,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [31:0] sh;
  logic [15:0] h;
  always_comb begin
    sh = raw >> {lane, 3'b000};
    h = lane[1] ? raw[31:16] : raw[15:0];
    misaligned = (width == W_HALF && lane[0]) || (width == W_WORD && lane != 2'b00);
    be = width == W_WORD ? 4'hF :
         width == W_HALF ? (lane[1] ? 4'hC : 4'h3) :
         width == W_BYTE ? 4'b0001 << lane : 4'h0;
    wdata_rep = width == W_WORD ? wdata :
                width == W_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rdata = width == W_WORD ? raw :
            width == W_HALF ? {{16{sign & h[15]}}, h} :
            width == W_BYTE ? {{24{sign & sh[7]}}, sh[7:0]} : 32'h0;
  end
endmodule

// File: rtl/sr_dmem.sv
// sr_dmem: single-cycle data memory with byte/half/word lanes and an MMIO page.
module sr_dmem
  import sr_dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [19:0] MMIO_PAGE  = 20'hFFFF0,
  parameter logic [15:0] ERR_MAX    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmAddr,
  input  logic [31:0] dmDataW,
  input  logic        dmWe,
  input  logic        op_byte,
  input  logic        op_half,
  input  logic        op_word,
  input  logic        dmSign,
  output logic [31:0] dmDataR,
  output logic        dmErr,
  output logic        errSticky,
  output logic [31:0] gpioOut
);
  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
  width_e width;
  logic active, mis, ok, ram_sel, ram_we, mmio_wr, err_clr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [11:0] off;
  logic [31:0] raw, ext, wrep, mmio_rd;
  logic [3:0] be;
  logic [31:0] gpio_q, gpio_d, cycle_q, cycle_d, err_addr_q, err_addr_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic err_sticky_q, err_sticky_d;
  sr_dmem_align u_align (
    .width(width), .lane(dmAddr[1:0]), .wdata(dmDataW), .sign(dmSign), .raw(raw),
    .be(be), .wdata_rep(wrep), .rdata(ext), .misaligned(mis)
  );
  always_comb begin
    width = width_sel(op_byte, op_half, op_word);
    active = width != W_NONE;
    ok = active && !mis;
    ram_sel = dmAddr[31:12] != MMIO_PAGE;
    idx = dmAddr[DEPTH_LOG2+1:2];
    off = dmAddr[11:0];
    raw = mem[idx];
    mmio_rd = off == DM_GPIO    ? gpio_q :
              off == DM_CYCLE   ? cycle_q :
              off == DM_ERRCNT  ? {16'h0, err_cnt_q} :
              off == DM_ERRADDR ? err_addr_q : 32'h0;
    dmDataR = !ok ? 32'h0 : ram_sel ? ext : mmio_rd;
    dmErr = active && mis;
    ram_we = !rst && ok && ram_sel && dmWe;
    // Only full-word stores reach MMIO registers; narrower ones are dropped.
    mmio_wr = !rst && ok && !ram_sel && dmWe && width == W_WORD;
    err_clr = mmio_wr && off == DM_ERRCNT;
    gpio_d = (mmio_wr && off == DM_GPIO) ? dmDataW : gpio_q;
    cycle_d = cycle_q + 32'd1;
    err_cnt_d = err_clr ? 16'h0 : (dmErr && err_cnt_q != ERR_MAX) ? err_cnt_q + 16'd1 : err_cnt_q;
    err_sticky_d = !err_clr && (err_sticky_q || dmErr);
    err_addr_d = dmErr ? dmAddr : err_addr_q;
    gpioOut = gpio_q;
    errSticky = err_sticky_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q <= 32'h0;
      cycle_q <= 32'h0;
      err_cnt_q <= 16'h0;
      err_addr_q <= 32'h0;
      err_sticky_q <= 1'b0;
    end else begin
      gpio_q <= gpio_d;
      cycle_q <= cycle_d;
      err_cnt_q <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_sticky_q <= err_sticky_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  end
endmodule

// File: tb/tb_sr_dmem.sv
// tb_sr_dmem: directed self-checking bench for sr_dmem.
module tb_sr_dmem;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] dmAddr, dmDataW, dmDataR, gpioOut;
  logic dmWe, op_byte, op_half, op_word, dmSign, dmErr, errSticky;
  int errors = 0;
  int checks = 0;
  localparam logic [2:0] N = 3'b000, B = 3'b001, H = 3'b010, W = 3'b100;
  sr_dmem dut (
    .clk(clk), .rst(rst), .dmAddr(dmAddr), .dmDataW(dmDataW), .dmWe(dmWe),
    .op_byte(op_byte), .op_half(op_half), .op_word(op_word), .dmSign(dmSign),
    .dmDataR(dmDataR), .dmErr(dmErr), .errSticky(errSticky), .gpioOut(gpioOut)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [2:0] op, input logic s);
    dmAddr = a; dmDataW = d; dmWe = we;
    {op_word, op_half, op_byte} = op; dmSign = s;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, N, 1'b0);
    tick(); tick();
    chk("rst_gpio", gpioOut, 32'h0);
    chk("rst_sticky", {31'h0, errSticky}, 32'h0);
    rst = 1'b0;
    drive(32'hFFFF0004, 32'h0, 1'b0, W, 1'b0);
    chk("cycle_first", dmDataR, 32'h0);
    repeat (5) tick();
    chk("cycle_5", dmDataR, 32'h5);
    drive(32'h10, 32'h800000F0, 1'b1, W, 1'b0); tick();
    drive(32'h10, 32'h0, 1'b0, B, 1'b1);
    chk("lb_sign", dmDataR, 32'hFFFFFFF0);
    chk("lb_err", {31'h0, dmErr}, 32'h0);
    drive(32'h10, 32'h0, 1'b0, B, 1'b0);
    chk("lbu", dmDataR, 32'h000000F0);
    drive(32'h12, 32'h0, 1'b0, H, 1'b1);
    chk("lh_sign", dmDataR, 32'hFFFF8000);
    drive(32'h10, 32'h12345678, 1'b1, W, 1'b0);
    chk("rdw_old", dmDataR, 32'h800000F0);
    tick();
    drive(32'h10, 32'h0, 1'b0, W, 1'b0);
    chk("rdw_new", dmDataR, 32'h12345678);
    drive(32'h20, 32'h11223344, 1'b1, W, 1'b0); tick();
    drive(32'h21, 32'hFFFFFFAB, 1'b1, B, 1'b0); tick();
    drive(32'h20, 32'h0, 1'b0, W, 1'b0);
    chk("sb_lane1", dmDataR, 32'h1122AB44);
    drive(32'h22, 32'h1234BEEF, 1'b1, H, 1'b0); tick();
    drive(32'h20, 32'h0, 1'b0, W, 1'b0);
    chk("sh_hi", dmDataR, 32'hBEEFAB44);
    drive(32'h20, 32'h0, 1'b0, W | B, 1'b0);
    chk("prio_word", dmDataR, 32'hBEEFAB44);
    drive(32'h30, 32'hCAFEF00D, 1'b1, W, 1'b0); tick();
    drive(32'h31, 32'h0, 1'b0, H, 1'b1);
    chk("mis_h_err", {31'h0, dmErr}, 32'h1);
    chk("mis_h_data", dmDataR, 32'h0);
    tick();
    drive(32'h32, 32'hFFFFFFFF, 1'b1, W, 1'b0);
    chk("mis_w_err", {31'h0, dmErr}, 32'h1);
    tick();
    drive(32'h30, 32'h0, 1'b0, W, 1'b0);
    chk("mis_w_nowrite", dmDataR, 32'hCAFEF00D);
    chk("sticky_set", {31'h0, errSticky}, 32'h1);
    drive(32'hFFFF0008, 32'h0, 1'b0, W, 1'b0);
    chk("errcnt_2", dmDataR, 32'h2);
    drive(32'hFFFF000C, 32'h0, 1'b0, W, 1'b0);
    chk("erraddr", dmDataR, 32'h32);
    drive(32'hFFFF0008, 32'h0, 1'b1, W, 1'b0); tick();
    drive(32'hFFFF0008, 32'h0, 1'b0, W, 1'b0);
    chk("errcnt_clr", dmDataR, 32'h0);
    chk("sticky_clr", {31'h0, errSticky}, 32'h0);
    drive(32'hFFFF000C, 32'h0, 1'b0, W, 1'b0);
    chk("erraddr_kept", dmDataR, 32'h32);
    drive(32'hFFFF0000, 32'hDEADBEEF, 1'b1, W, 1'b0);
    chk("gpio_pre", gpioOut, 32'h0);
    tick();
    chk("gpio_set", gpioOut, 32'hDEADBEEF);
    drive(32'hFFFF0000, 32'h11, 1'b1, B, 1'b0); tick();
    chk("gpio_byte_ign", gpioOut, 32'hDEADBEEF);
    drive(32'hFFFF0000, 32'h0, 1'b0, B, 1'b1);
    chk("mmio_byte_rd", dmDataR, 32'hDEADBEEF);
    drive(32'h0, 32'h55, 1'b1, W, 1'b0); tick();
    drive(32'h1000, 32'h0, 1'b0, W, 1'b0);
    chk("alias", dmDataR, 32'h55);
    drive(32'h0, 32'h99, 1'b1, N, 1'b1);
    chk("idle_data", dmDataR, 32'h0);
    chk("idle_err", {31'h0, dmErr}, 32'h0);
    tick();
    drive(32'h0, 32'h0, 1'b0, W, 1'b0);
    chk("idle_nowrite", dmDataR, 32'h55);
    force dut.cycle_q = 32'hFFFFFFFF;
    drive(32'hFFFF0004, 32'h0, 1'b0, W, 1'b0);
    chk("cycle_max", dmDataR, 32'hFFFFFFFF);
    release dut.cycle_q;
    tick();
    chk("cycle_wrap", dmDataR, 32'h0);
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    drive(32'h2, 32'h0, 1'b0, W, 1'b0); tick();
    drive(32'hFFFF0008, 32'h0, 1'b0, W, 1'b0);
    chk("errcnt_max", dmDataR, 32'h0000FFFF);
    drive(32'h2, 32'h0, 1'b0, W, 1'b0); tick();
    drive(32'hFFFF0008, 32'h0, 1'b0, W, 1'b0);
    chk("errcnt_sat", dmDataR, 32'h0000FFFF);
    rst = 1'b1;
    drive(32'h0, 32'h12121212, 1'b1, W, 1'b0); tick();
    chk("rst2_gpio", gpioOut, 32'h0);
    chk("rst2_sticky", {31'h0, errSticky}, 32'h0);
    rst = 1'b0;
    drive(32'h0, 32'h0, 1'b0, W, 1'b0);
    chk("rst2_ram", dmDataR, 32'h55);
    drive(32'hFFFF0008, 32'h0, 1'b0, W, 1'b0);
    chk("rst2_errcnt", dmDataR, 32'h0);
    drive(32'hFFFF0004, 32'h0, 1'b0, W, 1'b0);
    chk("rst2_cycle", dmDataR, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
